// File: rtl/eje01.sv
// Fire alarm / smoke extractor controller with presence lighting.
// Optional presence hold timer is built when EJE01_HOLD_EN is defined.
module eje01 #(
    parameter int F_CONFIRM = 2,
    parameter int A_CLEAR   = 2,
    parameter int P_HOLD    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sf,
    input  logic       sm,
    output logic       A,
    output logic       E,
    output logic       P,
    output logic [1:0] fire_state
);

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_DETECT = 2'd1,
        F_ALARM  = 2'd2,
        F_CLEAR  = 2'd3
    } fire_t;

    localparam logic [7:0] CONFIRM_N = 8'(F_CONFIRM);
    localparam logic [7:0] CLEAR_N   = 8'(A_CLEAR);

    if (F_CONFIRM < 1 || F_CONFIRM > 255) begin : g_bad_confirm
        $error("eje01: F_CONFIRM out of range 1..255");
    end
    if (A_CLEAR < 1 || A_CLEAR > 255) begin : g_bad_clear
        $error("eje01: A_CLEAR out of range 1..255");
    end
    if (P_HOLD < 0 || P_HOLD > 255) begin : g_bad_hold
        $error("eje01: P_HOLD out of range 0..255");
    end

    fire_t      state, state_nx;
    logic [7:0] cnt, cnt_nx, cnt_inc;
    logic       pres, pres_nx;
    logic       alarm_nx, ext_nx;

    // Shared confirm/clear counter; only one of the two is ever live.
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            F_IDLE: begin
                if (sf) begin
                    state_nx = F_DETECT;
                    cnt_nx   = 8'd0;
                end
            end
            F_DETECT: begin
                if (!sf) begin
                    state_nx = F_IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc >= CONFIRM_N) state_nx = F_ALARM;
                end
            end
            F_ALARM: begin
                if (!sf) begin
                    state_nx = F_CLEAR;
                    cnt_nx   = 8'd0;
                end
            end
            F_CLEAR: begin
                if (sf) begin
                    state_nx = F_ALARM;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc >= CLEAR_N) state_nx = F_IDLE;
                end
            end
            default: begin
                state_nx = F_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= F_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef EJE01_HOLD_EN
    logic [7:0] hold, hold_nx;

    always_comb begin
        pres_nx = pres;
        hold_nx = hold;
        if (sm) begin
            pres_nx = 1'b1;
            hold_nx = 8'(P_HOLD);
        end else if (hold != 8'd0) begin
            hold_nx = hold - 8'd1;
        end else begin
            pres_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold <= 8'd0;
        else       hold <= hold_nx;
    end
`else
    always_comb begin
        pres_nx = sm;
    end
`endif

    // Outputs are flops loaded from next-state decode, so they change
    // on the same edge as the state they reflect.
    always_comb begin
        alarm_nx = (state_nx == F_ALARM) || (state_nx == F_CLEAR);
        ext_nx   = (state_nx != F_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pres <= 1'b0;
            A    <= 1'b0;
            E    <= 1'b0;
            P    <= 1'b0;
        end else begin
            pres <= pres_nx;
            A    <= alarm_nx;
            E    <= ext_nx;
            P    <= pres_nx | alarm_nx;
        end
    end

    assign fire_state = state;

endmodule

// File: tb/tb_eje01.sv
// Bench for eje01: directed scenarios then randomized runs against a
// run-length reference model of the fire and presence rules.
module tb_eje01;

    localparam int F_CONFIRM = 2;
    localparam int A_CLEAR   = 2;
    localparam int P_HOLD    = 3;
`ifdef EJE01_HOLD_EN
    localparam int HOLD_EFF = P_HOLD;
`else
    localparam int HOLD_EFF = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sf = 1'b0;
    logic       sm = 1'b0;
    logic       A, E, P;
    logic [1:0] fire_state;

    int checks = 0;
    int errors = 0;

    eje01 #(.F_CONFIRM(F_CONFIRM), .A_CLEAR(A_CLEAR), .P_HOLD(P_HOLD)) dut (
        .clk(clk), .reset(reset), .sf(sf), .sm(sm),
        .A(A), .E(E), .P(P), .fire_state(fire_state)
    );

    always #5 clk = ~clk;

    // Reference model: counts consecutive samples rather than tracking states.
    int run_hi, run_lo, sm_age;
    bit m_e, m_a;

    function automatic void model_reset();
        m_e = 1'b0; m_a = 1'b0; run_hi = 0; run_lo = 0; sm_age = 1000;
    endfunction

    function automatic void model_edge(input bit f, input bit m);
        if (m_a) begin
            if (f) run_lo = 0;
            else begin
                run_lo++;
                if (run_lo == A_CLEAR + 1) begin m_a = 1'b0; m_e = 1'b0; end
            end
        end else if (m_e) begin
            if (f) begin
                run_hi++;
                if (run_hi == F_CONFIRM + 1) begin m_a = 1'b1; run_lo = 0; end
            end else m_e = 1'b0;
        end else if (f) begin
            m_e = 1'b1; run_hi = 1;
        end
        if (m) sm_age = 0;
        else if (sm_age < 1000) sm_age++;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_bit({tag, ".A"}, A, m_a);
        check_bit({tag, ".E"}, E, m_e);
        check_bit({tag, ".P"}, P, (sm_age <= HOLD_EFF) || m_a);
    endtask

    task automatic step(input string tag, input bit f, input bit m);
        @(negedge clk);
        sf = f; sm = m;
        @(posedge clk);
        model_edge(f, m);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sf = 1'b1; sm = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (2) begin
            @(posedge clk); #1;
            check_outputs("rst_hold");
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int f_len, m_len;
        bit f_val, m_val;
        model_reset();
        #2;
        do_reset();

        // presence hold after two motion edges
        repeat (2) step("pres_on", 1'b0, 1'b1);
        repeat (5) step("pres_off", 1'b0, 1'b0);

        // full alarm then clearance
        repeat (4) step("fire_on", 1'b1, 1'b0);
        repeat (4) step("fire_off", 1'b0, 1'b0);

        // short blip never reaches alarm
        repeat (2) step("blip_on", 1'b1, 1'b0);
        repeat (2) step("blip_off", 1'b0, 1'b0);
        checks++;
        assert (fire_state === 2'd0) else begin
            errors++;
            $error("FAIL blip_idle observed=%0d expected=0", fire_state);
        end

        // re-fire during clearance restarts the clear count
        repeat (3) step("reclr_on", 1'b1, 1'b0);
        step("reclr_lo", 1'b0, 1'b0);
        step("reclr_hi", 1'b1, 1'b0);
        repeat (3) step("reclr_off", 1'b0, 1'b0);

        // alarm forces presence lighting; it drops with the alarm
        step("force_sm", 1'b0, 1'b1);
        repeat (8) step("force_on", 1'b1, 1'b0);
        repeat (3) step("force_off", 1'b0, 1'b0);

        // asynchronous reset in the middle of a cycle while in alarm
        repeat (3) step("pre_rst", 1'b1, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("mid_rst");
        @(posedge clk); #1;
        check_outputs("mid_rst_hold");
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 1'b1, 1'b1);
        step("post_rst2", 1'b0, 1'b0);

        // randomized runs
        f_len = 0; m_len = 0; f_val = 1'b0; m_val = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (f_len == 0) begin f_val = ~f_val; f_len = $urandom_range(1, 6); end
            if (m_len == 0) begin m_val = ~m_val; m_len = $urandom_range(1, 7); end
            f_len--; m_len--;
            if ($urandom_range(0, 149) == 0) do_reset();
            else step("rand", f_val, m_val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eje01.md
EJE01 -- requirements
Module: eje01

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 sf  input  1  fire/smoke sensor, 1 = fire detected; synchronous to clk.
REQ-004 sm  input  1  motion sensor, 1 = presence detected; synchronous to clk.
REQ-005 A  output  1  alarm siren, registered.
REQ-006 E  output  1  smoke extractor (fan) enable, registered.
REQ-007 P  output  1  presence lighting, registered.
REQ-008 Parameter F_CONFIRM, default 2: extra consecutive sf=1 edges required in DETECT before alarm; legal range 1..255.
REQ-009 Parameter A_CLEAR, default 2: extra consecutive sf=0 edges required in CLEAR before returning to idle; legal range 1..255.
REQ-010 Parameter P_HOLD, default 3: edges P stays on after sm falls; legal range 0..255.

Function
REQ-011 All outputs SHALL be Moore or registered; an input sampled at edge n affects outputs only after edge n.
REQ-012 Fire FSM SHALL have exactly four states: F_IDLE (A=0, E=0), F_DETECT (A=0, E=1), F_ALARM (A=1, E=1), F_CLEAR (A=1, E=1).
REQ-013 F_IDLE: sf=1 -> F_DETECT and confirm counter cleared; sf=0 -> stay.
REQ-014 F_DETECT: sf=0 -> F_IDLE; sf=1 -> counter+1; on the edge where the counter reaches F_CONFIRM -> F_ALARM.
REQ-015 Consequently A SHALL rise on the (F_CONFIRM+1)-th consecutive edge sampling sf=1; E SHALL rise on the first.
REQ-016 F_ALARM: sf=0 -> F_CLEAR and clear counter cleared; sf=1 -> stay.
REQ-017 F_CLEAR: sf=1 -> F_ALARM; sf=0 -> counter+1; on the edge where the counter reaches A_CLEAR -> F_IDLE.
REQ-018 Consequently A and E SHALL fall together on the (A_CLEAR+1)-th consecutive edge sampling sf=0 after alarm.
REQ-019 Counters SHALL be 8 bits and saturating; a counter SHALL never wrap.
REQ-020 Presence: each edge sampling sm=1 SHALL set P=1 and reload the hold counter with P_HOLD.
REQ-021 Each edge sampling sm=0 with hold counter >0 SHALL decrement the counter and keep P=1; with counter =0, P SHALL go to 0.
REQ-022 P SHALL therefore fall on the (P_HOLD+1)-th consecutive edge sampling sm=0; with P_HOLD=0, P follows sm with one-edge latency.
REQ-023 While fire FSM is in F_ALARM or F_CLEAR, P SHALL be forced to 1; the hold counter keeps running underneath, and on leaving F_CLEAR P reverts to the presence logic value.
REQ-024 Presence and fire logic SHALL operate independently; simultaneous changes of sf and sm on one edge are each processed per their own rules.

Reset
REQ-025 reset=1 SHALL immediately, without waiting for clk, force fire FSM to F_IDLE, all counters to 0, and A=0, E=0, P=0.
REQ-026 Reset asserted mid-operation (any state, any count) SHALL abort it; after release the block starts from F_IDLE with no memory of prior inputs.
REQ-027 First edge after reset release SHALL process sf/sm normally.

Configuration
REQ-028 Macro EJE01_HOLD_EN: when defined, presence hold timer of REQ-020..022 is built; when undefined, no hold counter exists, P_HOLD is ignored, and P equals sm registered at each edge (REQ-023 forcing still applies).

Verification
REQ-029 Reset held 2 cycles with sf=1, sm=1 -> A=E=P=0 throughout, including asynchronously mid-cycle.
REQ-030 sm=1 for 2 edges then 0 (defaults, macro on) -> P=1 after first edge, P falls on 4th edge with sm=0; macro off -> P falls on 1st edge with sm=0.
REQ-031 sf=1 for 4 edges -> E=1 after edge 1, A=1 after edge 3; then sf=0 -> A, E fall after 3rd low edge.
REQ-032 sf=1 for 2 edges then 0 -> E pulses 2 cycles, A never asserts, FSM back to F_IDLE.
REQ-033 In F_CLEAR after 1 low edge, sf=1 one edge -> returns F_ALARM, A stays 1; clear count restarts from 0.
REQ-034 Alarm active with sm=0 and hold expired -> P=1 while A=1, P=0 on same edge A falls.
